// File: rtl/bus_cmp_pkg.sv
// Shared types and default sizes for the bus match monitor and its helpers.
package bus_cmp_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_STABLE_N = 3;
    localparam int DEF_CNT_W    = 16;

    // Capture -> compare -> emit sequence run once per accepted sample
    typedef enum logic [1:0] {
        S_WAIT,
        S_CMP,
        S_EMIT
    } state_t;

endpackage

// File: rtl/tick_rise_det.sv
// Rising-edge detector for the divider's sample strobe, gated by enable.
// A strobe that is already high on the first cycle after reset counts as an edge.
module tick_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    output logic sample_evt
);

    logic tick_q;

    // Remember the previous strobe level every cycle, regardless of enable
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign sample_evt = tick & ~tick_q & enable;

endmodule

// File: rtl/bus_match_monitor.sv
// Samples two buses on each tick edge, debounces the compare result over
// STABLE_N samples and reports each new stable result once on valid/ready.
module bus_match_monitor
    import bus_cmp_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STABLE_N = DEF_STABLE_N,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_equal,
    output logic [WIDTH-1:0] res_diff,
    output logic [CNT_W-1:0] mis_count,
    output logic             overrun
);

    localparam int SC_W = $clog2(STABLE_N + 1);

    state_t           state;
    logic             sample_evt;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [SC_W-1:0]  stable_cnt;

    // Most recent compared sample; also the debounce candidate
    logic             cand_eq;
    logic [WIDTH-1:0] cand_diff;

    // Last result actually loaded onto the output
    logic             last_vld;
    logic             last_eq;
    logic [WIDTH-1:0] last_diff;

    logic             cmp_eq;
    logic [WIDTH-1:0] cmp_diff;
    logic             want_emit;
    logic             can_load;

    tick_rise_det u_rise (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .enable     (enable),
        .sample_evt (sample_evt)
    );

    assign cmp_eq    = (a_s == b_s);
    assign cmp_diff  = a_s ^ b_s;
    assign want_emit = (stable_cnt == SC_W'(STABLE_N)) &&
                       (!last_vld || ({cand_eq, cand_diff} != {last_eq, last_diff}));
    assign can_load  = ~res_valid | res_ready;

    // Sequencer, debounce counter, output registers and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_WAIT;
            a_s        <= '0;
            b_s        <= '0;
            stable_cnt <= '0;
            cand_eq    <= 1'b0;
            cand_diff  <= '0;
            last_vld   <= 1'b0;
            last_eq    <= 1'b0;
            last_diff  <= '0;
            res_valid  <= 1'b0;
            res_equal  <= 1'b0;
            res_diff   <= '0;
            mis_count  <= '0;
            overrun    <= 1'b0;
        end else begin
            // An accepted result retires unless an emit below reloads it
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                S_WAIT: begin
                    if (sample_evt) begin
                        a_s   <= bus_a;
                        b_s   <= bus_b;
                        state <= S_CMP;
                    end else if (!enable) begin
                        stable_cnt <= '0;
                    end
                end

                S_CMP: begin
                    // stable_cnt==0 restarts at 1 even when the old candidate matches
                    if ({cmp_eq, cmp_diff} == {cand_eq, cand_diff}) begin
                        if (stable_cnt != SC_W'(STABLE_N)) begin
                            stable_cnt <= stable_cnt + SC_W'(1);
                        end
                    end else begin
                        stable_cnt <= SC_W'(1);
                    end
                    cand_eq   <= cmp_eq;
                    cand_diff <= cmp_diff;
                    state     <= S_EMIT;
                end

                S_EMIT: begin
                    if (want_emit) begin
                        if (can_load) begin
                            res_valid <= 1'b1;
                            res_equal <= cand_eq;
                            res_diff  <= cand_diff;
                            last_vld  <= 1'b1;
                            last_eq   <= cand_eq;
                            last_diff <= cand_diff;
                            if (!cand_eq && (mis_count != '1)) begin
                                mis_count <= mis_count + CNT_W'(1);
                            end
                        end else begin
                            // Output still occupied: drop this result
                            overrun <= 1'b1;
                        end
                    end
                    state <= S_WAIT;
                end

                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_match_monitor.sv
// Directed bench for bus_match_monitor with a behavioural reference model.
module tb_bus_match_monitor;

    localparam int WIDTH    = 8;
    localparam int STABLE_N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             enable;
    logic             res_ready;
    logic [WIDTH-1:0] bus_a;
    logic [WIDTH-1:0] bus_b;

    logic             v16, eq16, ov16;
    logic [WIDTH-1:0] diff16;
    logic [15:0]      mis16;
    logic             v2, eq2, ov2;
    logic [WIDTH-1:0] diff2;
    logic [1:0]       mis2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_match_monitor #(.WIDTH(WIDTH), .STABLE_N(STABLE_N), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .bus_a(bus_a), .bus_b(bus_b),
        .res_valid(v16), .res_ready(res_ready), .res_equal(eq16),
        .res_diff(diff16), .mis_count(mis16), .overrun(ov16)
    );

    bus_match_monitor #(.WIDTH(WIDTH), .STABLE_N(STABLE_N), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .bus_a(bus_a), .bus_b(bus_b),
        .res_valid(v2), .res_ready(res_ready), .res_equal(eq2),
        .res_diff(diff2), .mis_count(mis2), .overrun(ov2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample history is tracked as a run of identical {eq,diff} values;
    // a result is reported two cycles after capture when the run is long enough.
    bit             model_ok = 1'b0;
    bit             m_tick_prev;
    int             busy;
    int             run_len;
    bit             run_eq;
    bit [WIDTH-1:0] run_diff;
    bit             last_v, last_eq;
    bit [WIDTH-1:0] last_diff;
    bit             e_v, e_eq, e_ov;
    bit [WIDTH-1:0] e_diff;
    int             e_mis;
    bit             fire;
    bit             s_eq;
    bit [WIDTH-1:0] s_diff;

    always @(posedge clk) begin
        if (rst) begin
            model_ok    = 1'b1;
            m_tick_prev = 1'b0;
            busy = 0; run_len = 0; run_eq = 0; run_diff = '0;
            last_v = 0; last_eq = 0; last_diff = '0;
            e_v = 0; e_eq = 0; e_diff = '0; e_mis = 0; e_ov = 0;
        end else begin
            fire = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    fire = (run_len >= STABLE_N) &&
                           (!last_v || run_eq != last_eq || run_diff != last_diff);
                end
            end else if (!enable) begin
                run_len = 0;
            end else if (tick && !m_tick_prev) begin
                s_eq   = (bus_a == bus_b);
                s_diff = bus_a ^ bus_b;
                if (run_len > 0 && s_eq == run_eq && s_diff == run_diff) run_len++;
                else run_len = 1;
                run_eq   = s_eq;
                run_diff = s_diff;
                busy     = 2;
            end

            if (fire && (!e_v || res_ready)) begin
                e_v = 1; e_eq = run_eq; e_diff = run_diff;
                last_v = 1; last_eq = run_eq; last_diff = run_diff;
                if (!run_eq) e_mis++;
            end else begin
                if (fire) e_ov = 1;
                if (e_v && res_ready) e_v = 0;
            end
            m_tick_prev = tick;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        #1;
        if (model_ok) begin
            check("valid16", {31'b0, v16}, {31'b0, e_v});
            check("equal16", {31'b0, eq16}, {31'b0, e_eq});
            check("diff16", {24'b0, diff16}, {24'b0, e_diff});
            check("mis16", {16'b0, mis16}, (e_mis > 65535) ? 32'd65535 : 32'(e_mis));
            check("overrun16", {31'b0, ov16}, {31'b0, e_ov});
            check("valid2", {31'b0, v2}, {31'b0, e_v});
            check("diff2", {24'b0, diff2}, {24'b0, e_diff});
            check("mis2", {30'b0, mis2}, (e_mis > 3) ? 32'd3 : 32'(e_mis));
            check("overrun2", {31'b0, ov2}, {31'b0, e_ov});
        end
    end

    // Handshake log from the 16-bit instance
    int             hs = 0;
    bit             hs_eq;
    bit [WIDTH-1:0] hs_diff;

    always @(negedge clk) begin
        #1;
        if (model_ok && !rst && v16 && res_ready) begin
            hs++;
            hs_eq   = eq16;
            hs_diff = diff16;
            $display("report %0d: equal=%0b diff=0x%02h mis=%0d at %0t", hs, eq16, diff16, mis16, $time);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input int hi, input int lo);
        tick = 1'b1;
        repeat (hi) @(negedge clk);
        tick = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int hs0;

    initial begin
        rst = 1'b1; tick = 1'b0; enable = 1'b1; res_ready = 1'b1;
        bus_a = '0; bus_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {31'b0, v16}, 32'd0);
        check("rst_mis", {16'b0, mis16}, 32'd0);
        check("rst_overrun", {31'b0, ov16}, 32'd0);

        // 1: stable match reported once, with T+3 latency
        bus_a = 8'h5A; bus_b = 8'h5A;
        pulse(1, 7);
        pulse(1, 7);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check("t1_valid_early", {31'b0, v16}, 32'd0);
        @(negedge clk);
        check("t1_valid_at_t3", {31'b0, v16}, 32'd1);
        check("t1_equal", {31'b0, eq16}, 32'd1);
        check("t1_diff", {24'b0, diff16}, 32'h00);
        @(negedge clk);
        check("t1_valid_drop", {31'b0, v16}, 32'd0);
        repeat (4) @(negedge clk);
        pulse(1, 7);
        check("t1_reports", hs, 32'd1);
        check("t1_mis", {16'b0, mis16}, 32'd0);

        // 2: mismatch with a two-sample glitch in the middle
        bus_b = 8'h5B; pulse(1, 7);
        bus_b = 8'h5F; pulse(1, 7); pulse(1, 7);
        check("t2_glitch_none", hs, 32'd1);
        bus_b = 8'h5B; pulse(1, 7); pulse(1, 7); pulse(1, 7);
        check("t2_reports", hs, 32'd2);
        check("t2_equal", {31'b0, hs_eq}, 32'd0);
        check("t2_diff", {24'b0, hs_diff}, 32'h01);
        check("t2_mis", {16'b0, mis16}, 32'd1);

        // 3: long strobes give one capture each; disabled sampling captures nothing
        bus_a = 8'h11; bus_b = 8'h11;
        pulse(4, 28); pulse(4, 28);
        check("t3_two_pulses", hs, 32'd2);
        pulse(4, 28);
        check("t3_three_pulses", hs, 32'd3);
        enable = 1'b0;
        bus_a = 8'h22; bus_b = 8'h23;
        repeat (4) pulse(4, 28);
        check("t3_disabled_reports", hs, 32'd3);
        check("t3_disabled_valid", {31'b0, v16}, 32'd0);
        enable = 1'b1;

        // 4: result held while not ready; second stable result overruns
        do_reset();
        check("t4_rst_mis", {16'b0, mis16}, 32'd0);
        res_ready = 1'b0;
        bus_a = 8'h30; bus_b = 8'h31;
        repeat (3) pulse(1, 7);
        check("t4_valid", {31'b0, v16}, 32'd1);
        bus_b = 8'h30;
        repeat (3) pulse(1, 7);
        check("t4_overrun", {31'b0, ov16}, 32'd1);
        check("t4_diff_held", {24'b0, diff16}, 32'h01);
        check("t4_equal_held", {31'b0, eq16}, 32'd0);
        check("t4_mis", {16'b0, mis16}, 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_drop", {31'b0, v16}, 32'd0);
        check("t4_overrun_sticky", {31'b0, ov16}, 32'd1);

        // 5: mismatch counter saturation on the narrow instance
        do_reset();
        hs0 = hs;
        for (int i = 0; i < 5; i++) begin
            bus_a = 8'h40; bus_b = 8'h40; repeat (3) pulse(1, 7);
            bus_b = 8'h4F;                repeat (3) pulse(1, 7);
        end
        check("t5_reports", hs - hs0, 32'd10);
        check("t5_mis16", {16'b0, mis16}, 32'd5);
        check("t5_mis2_sat", {30'b0, mis2}, 32'd3);

        // 6: reset during compare discards the in-flight sample
        bus_a = 8'h01; bus_b = 8'h02;
        pulse(1, 7); pulse(1, 7);
        tick = 1'b1;
        @(negedge clk);
        rst = 1'b1; tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid", {31'b0, v16}, 32'd0);
        check("t6_equal", {31'b0, eq16}, 32'd0);
        check("t6_diff", {24'b0, diff16}, 32'h00);
        check("t6_mis", {16'b0, mis16}, 32'd0);
        check("t6_overrun", {31'b0, ov16}, 32'd0);
        hs0 = hs;
        repeat (7) @(negedge clk);
        pulse(1, 7); pulse(1, 7);
        check("t6_two_fresh", hs - hs0, 32'd0);
        pulse(1, 7);
        check("t6_three_fresh", hs - hs0, 32'd1);
        check("t6_diff_rep", {24'b0, hs_diff}, 32'h03);
        check("t6_mis_after", {16'b0, mis16}, 32'd1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
